// File: rtl/arb_8_rr_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin arbiter.
package arb_8_rr_pkg;

    localparam int N_REQ  = 8;   // number of requesters
    localparam int ID_W   = 3;   // width of a requester index
    localparam int HOLD_W = 8;   // width of the grant hold counter

    // Pointer value after reset: the next search then starts at requester 0.
    localparam logic [ID_W-1:0] PTR_RST = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // One-hot vector with only bit 'id' set.
    function automatic logic [N_REQ-1:0] onehot_id(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rot_enc_8.sv
// Rotating priority encoder: lowest set request index at or above s wins, wrapping 7 -> 0.
module rot_enc_8
    import arb_8_rr_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  s,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    // Scan from the farthest offset down to offset 0 so the nearest set bit overrides.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[s + ID_W'(k)]) begin
                id    = s + ID_W'(k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_8_rr.sv
// 8-requester round-robin arbiter with hold limit, one-cycle release gap and registered outputs.
module arb_8_rr
    import arb_8_rr_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

    state_e             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_gnt_id;
    logic [HOLD_W-1:0]  r_hold;
    logic [N_REQ-1:0]   r_gnt;
    logic               r_busy;
    logic               r_timeout;

    state_e             w_state_nxt;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [ID_W-1:0]    w_gnt_id_nxt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic [N_REQ-1:0]   w_gnt_nxt;
    logic               w_busy_nxt;
    logic               w_timeout_nxt;

    logic [ID_W-1:0]    w_start;
    logic [ID_W-1:0]    w_enc_id;
    logic               w_enc_valid;
    logic               w_rel_done;
    logic               w_rel_drop;
    logic               w_rel_limit;

    // Search starts one past the last released grantee.
    assign w_start     = r_ptr + ID_W'(1);
    assign w_rel_done  = done;
    assign w_rel_drop  = ~req[r_gnt_id];
    assign w_rel_limit = (MAX_HOLD != 0) && (int'(r_hold) == MAX_HOLD);

    rot_enc_8 u_rot_enc (
        .req   (req),
        .s     (w_start),
        .id    (w_enc_id),
        .valid (w_enc_valid)
    );

    // Next-state, pointer, hold counter and next registered outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_id_nxt  = r_gnt_id;
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_hold_nxt = '0;
                if (w_enc_valid) begin
                    w_state_nxt  = ST_GRANT;
                    w_gnt_id_nxt = w_enc_id;
                    // Counter restarts; the first GRANT cycle counts as 1.
                    w_hold_nxt   = HOLD_W'(1);
                end
            end
            ST_GRANT: begin
                if (w_rel_done || w_rel_drop || w_rel_limit) begin
                    w_state_nxt   = ST_GAP;
                    w_ptr_nxt     = r_gnt_id;
                    w_hold_nxt    = '0;
                    // A normal release wins over a simultaneous hold-limit hit.
                    w_timeout_nxt = ~w_rel_done & ~w_rel_drop;
                end else if (r_hold != HOLD_SAT) begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == ST_GRANT);
        w_gnt_nxt  = w_busy_nxt ? onehot_id(w_gnt_id_nxt) : '0;
    end

    // State and output registers; reset clears the grant immediately without a GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= PTR_RST;
            r_gnt_id  <= '0;
            r_hold    <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_hold    <= w_hold_nxt;
            r_gnt     <= w_gnt_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_arb_8_rr.sv
// Directed testbench for arb_8_rr: hold-limited instance (MAX_HOLD=4) plus an unlimited one.
module tb_arb_8_rr;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;
    logic [7:0] gnt0;
    logic [2:0] gnt_id0;
    logic       busy0;
    logic       timeout0;

    int n_tests = 0;
    int n_fail  = 0;

    arb_8_rr #(.MAX_HOLD(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    arb_8_rr #(.MAX_HOLD(0)) u_dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt0),
        .gnt_id  (gnt_id0),
        .busy    (busy0),
        .timeout (timeout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic [7:0] g, input logic b, input logic t);
        check_val({tag, ".gnt"},     32'(gnt),     32'(g));
        check_val({tag, ".busy"},    32'(busy),    32'(b));
        check_val({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        done  = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        req   = '0;
        done  = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        exp_out("rst", 8'h00, 1'b0, 1'b0);
        check_val("rst.gnt_id", 32'(gnt_id), 32'd0);

        // Single requester, done pulse, GAP then IDLE
        do_reset();
        req = 8'h01;
        tick();
        exp_out("t1.grant", 8'h01, 1'b1, 1'b0);
        check_val("t1.id", 32'(gnt_id), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        exp_out("t1.gap", 8'h00, 1'b0, 1'b0);
        tick();
        exp_out("t1.idle", 8'h00, 1'b0, 1'b0);
        tick();
        exp_out("t1.idle2", 8'h00, 1'b0, 1'b0);

        // ptr=2, then requesters 7 and 0 compete
        do_reset();
        req = 8'h04;
        tick();
        check_val("t2.id2", 32'(gnt_id), 32'd2);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h81;
        tick();
        exp_out("t2.idle", 8'h00, 1'b0, 1'b0);
        tick();
        exp_out("t2.g7", 8'h80, 1'b1, 1'b0);
        check_val("t2.id7", 32'(gnt_id), 32'd7);
        done = 1'b1;
        tick();
        done = 1'b0;
        exp_out("t2.gap", 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        exp_out("t2.g0", 8'h01, 1'b1, 1'b0);
        check_val("t2.id0", 32'(gnt_id), 32'd0);
        req = 8'h00;
        tick();

        // Hold limit of 4, re-grant, then done on the limit cycle
        do_reset();
        req = 8'h08;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_out("t3.hold", 8'h08, 1'b1, 1'b0);
        end
        tick();
        exp_out("t3.timeout", 8'h00, 1'b0, 1'b1);
        tick();
        exp_out("t3.idle", 8'h00, 1'b0, 1'b0);
        tick();
        exp_out("t3.regrant", 8'h08, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_out("t3.hold2", 8'h08, 1'b1, 1'b0);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        exp_out("t3.done_at_limit", 8'h00, 1'b0, 1'b0);
        tick();

        // Full rotation with all requests high
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_out("t4.grant", 8'(1 << (i % 8)), 1'b1, 1'b0);
            check_val("t4.id", 32'(gnt_id), 32'(i % 8));
            done = 1'b1;
            tick();
            done = 1'b0;
            exp_out("t4.gap", 8'h00, 1'b0, 1'b0);
            tick();
            exp_out("t4.idle", 8'h00, 1'b0, 1'b0);
        end
        req = 8'h00;
        tick();

        // Request withdrawn right after being picked
        do_reset();
        req = 8'h20;
        tick();
        req = 8'h00;
        exp_out("t5.grant", 8'h20, 1'b1, 1'b0);
        tick();
        exp_out("t5.release", 8'h00, 1'b0, 1'b0);
        tick();

        // Other request bits changing during GRANT are ignored
        do_reset();
        req = 8'h02;
        tick();
        req = 8'hFF;
        tick();
        exp_out("t6.hold", 8'h02, 1'b1, 1'b0);
        check_val("t6.id", 32'(gnt_id), 32'd1);
        req = 8'h03;
        done = 1'b1;
        tick();
        done = 1'b0;
        exp_out("t6.gap", 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        exp_out("t6.wrap", 8'h01, 1'b1, 1'b0);
        req = 8'h00;
        tick();

        // Asynchronous reset in the middle of a grant
        do_reset();
        req = 8'h01;
        tick();
        tick();
        exp_out("t7.pre", 8'h01, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        exp_out("t7.async", 8'h00, 1'b0, 1'b0);
        req = 8'h10;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        exp_out("t7.after", 8'h10, 1'b1, 1'b0);
        check_val("t7.id", 32'(gnt_id), 32'd4);
        req = 8'h00;
        tick();

        // MAX_HOLD=0: long hold past counter saturation, never times out
        do_reset();
        req = 8'h08;
        for (int k = 0; k < 270; k++) begin
            tick();
            check_val("t8.gnt", 32'(gnt0), 32'h08);
            check_val("t8.timeout", 32'(timeout0), 32'd0);
        end
        req = 8'h00;
        tick();
        check_val("t8.release", 32'(gnt0), 32'h00);
        check_val("t8.release_to", 32'(timeout0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_8_rr.md
ARB_8_RR -- requirements
Module: arb_8_rr

Interface
REQ-001 Parameter MAX_HOLD, default 15, maximum cycles one requester may hold a grant; 0 disables the limit.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req  input  8  request lines; bit n belongs to requester n.
REQ-005 done  input  1  current grantee finished with the shared resource; single-cycle pulse.
REQ-006 gnt  output  8  one-hot grant; all zero when no grant.
REQ-007 gnt_id  output  3  index of the current grantee; valid only while busy=1.
REQ-008 busy  output  1  high while a grant is held.
REQ-009 timeout  output  1  one-cycle pulse when a grant is revoked because of MAX_HOLD.

Function
REQ-010 The block SHALL implement three states: IDLE, GRANT and GAP.
REQ-011 All outputs SHALL be registered.
REQ-012 In IDLE with req=0, the block SHALL stay in IDLE.
REQ-013 In IDLE with req≠0, the block SHALL pick a winner from the req value sampled at that edge and enter GRANT on the next cycle; latency from req to gnt is 1 cycle.
REQ-014 Winner selection SHALL be round-robin: search from index ptr+1 upward, wrap 7→0, first set bit wins.
REQ-015 ptr SHALL hold the index of the last released grantee.
REQ-016 In GRANT: gnt = one-hot(gnt_id), busy=1, and the hold counter counts cycles spent in GRANT, starting at 1 in the first cycle.
REQ-017 GRANT SHALL exit to GAP at the next edge when any of these holds:
  - (a) done=1;
  - (b) req[gnt_id]=0;
  - (c) MAX_HOLD≠0 and the hold counter equals MAX_HOLD.
REQ-018 When exiting GRANT, ptr SHALL be loaded with gnt_id.
REQ-019 timeout SHALL be 1 only during the GAP cycle, and only if (c) was true while (a) and (b) were both false; (a) and (b) take precedence over (c).
REQ-020 GAP SHALL last exactly one cycle with gnt=0 and busy=0, then go to IDLE unconditionally; the minimum release-to-next-grant interval is 2 cycles.
REQ-021 done SHALL be ignored in IDLE and GAP.
REQ-022 A request withdrawn in the same cycle the winner is picked SHALL still be granted, then released via (b) after one GRANT cycle.
REQ-023 Changes on req bits other than req[gnt_id] during GRANT SHALL have no effect until the next IDLE.
REQ-024 With all eight req bits held high and done pulsed in each grantee's first GRANT cycle, grants SHALL rotate 0,1,…,7,0 with no requester skipped.
REQ-025 The hold counter SHALL be at least 8 bits wide, SHALL saturate rather than wrap, and SHALL clear on entry to GRANT.
REQ-026 gnt SHALL never have more than one bit set.

Reset
REQ-027 On rst_n=0, immediately and independent of clk, the block SHALL set: state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, hold counter=0, ptr=7.
REQ-028 Because ptr resets to 7, the first arbitration after reset SHALL favour requester 0.
REQ-029 Reset asserted mid-GRANT SHALL drop gnt within the same cycle, with no GAP cycle and no timeout pulse.
REQ-030 The first arbitration after rst_n rises SHALL occur at the first clk edge that finds state IDLE with req≠0.

Structure
REQ-031 State encodings and the width of the hold counter SHALL be placed in a shared package, together with the requester count (8) and the id width (3).
REQ-032 Winner selection SHALL be a purely combinational sub-module rot_enc_8 with:
  - inputs: req[7:0] and a start index s[2:0];
  - outputs: id[2:0] and valid;
  - behaviour: the lowest index at or above s wins, with wrap-around.
REQ-033 arb_8_rr SHALL drive rot_enc_8 with s = ptr+1 modulo 8.

Verification
REQ-034 Reset, then req=8'b0000_0001 -> one cycle later gnt=8'h01, gnt_id=0, busy=1; after a done pulse: one GAP cycle, then IDLE.
REQ-035 ptr=2, req=8'b1000_0001 -> gnt_id=7 is granted; after its release, with both bits still set, gnt_id=0 is granted next.
REQ-036 MAX_HOLD=4, req[3] held, done never pulsed -> gnt=8'h08 for exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle, then req[3] is re-granted 2 cycles after release.
REQ-037 In the cycle the hold counter reaches MAX_HOLD, done=1 -> release occurs with timeout=0.
REQ-038 req=8'hFF held, done pulsed every grant -> 16 grants in order 0..7,0..7; each grant 1 cycle long, each followed by GAP and IDLE cycles.
REQ-039 rst_n driven low 2 cycles into a grant, between clock edges -> gnt=0 and busy=0 immediately; after release, req=8'h10 -> gnt_id=4.
